// File: rtl/if_stage_fq_if.sv
// Fetch-stage bus bundle: split addr_ok/data_ok SRAM port, ID handshake
// and the EX redirect, seen from the fetch stage (master) or its peers.
interface if_stage_fq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              ds_allow_in;
    logic              fs_to_ds_valid;
    logic [ADDR_W-1:0] fs_pc;
    logic [DATA_W-1:0] fs_inst;
    logic [CNT_W-1:0]  fq_count;

    modport master (
        input  br_taken,
        input  br_target,
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata,
        input  ds_allow_in,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst,
        output fq_count
    );

    modport slave (
        output br_taken,
        output br_target,
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata,
        output ds_allow_in,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst,
        input  fq_count
    );
endinterface

// File: rtl/if_stage_fq.sv
// Fetch stage with an in-order instruction queue in front of ID.
// Owns the PC, keeps FQ_DEPTH credits across in-flight and queued fetches.
module if_stage_fq #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c00_0000)
) (
    input logic            clk,
    input logic            reset,
    if_stage_fq_if.master  fs
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam cnt_t            DEPTH = cnt_t'(FQ_DEPTH);
    localparam logic [CNT_W:0]  DEPTH_X = {1'b0, DEPTH};

    logic [ADDR_W-1:0] pc, pc_n;
    cnt_t              inflight, inflight_n;
    cnt_t              discard, discard_n;
    cnt_t              count, count_n;
    ptr_t              q_wp, q_wp_n, q_rp, q_rp_n;
    ptr_t              p_wp, p_wp_n, p_rp, p_rp_n;

    logic [ADDR_W-1:0] q_pc   [FQ_DEPTH];
    logic [DATA_W-1:0] q_inst [FQ_DEPTH];
    logic [ADDR_W-1:0] p_pc   [FQ_DEPTH];

    logic [CNT_W:0]    credit_sum;
    logic              req;
    logic              accept;
    logic              ret;
    logic              drop;
    logic              push;
    logic              pop;
    logic              head_v;
    logic              out_v;

    // Credits cover discard-pending requests, so a push always has room.
    always_comb begin
        credit_sum = {1'b0, inflight} + {1'b0, count};
        req        = !reset && (credit_sum < DEPTH_X);
        accept     = req && fs.inst_addr_ok;
        ret        = fs.inst_data_ok && (inflight != '0);
        drop       = ret && (discard != '0);
        push       = ret && !drop && !fs.br_taken;
        head_v     = (count != '0);
        out_v      = head_v && !fs.br_taken;
        pop        = out_v && fs.ds_allow_in;
    end

    assign fs.inst_req       = req;
    assign fs.inst_addr      = pc;
    assign fs.fs_to_ds_valid = out_v;
    assign fs.fs_pc          = head_v ? q_pc[q_rp]   : '0;
    assign fs.fs_inst        = head_v ? q_inst[q_rp] : '0;
    assign fs.fq_count       = count;

    always_comb begin
        inflight_n = inflight + cnt_t'(accept) - cnt_t'(ret);
        p_wp_n     = p_wp + ptr_t'(accept);
        p_rp_n     = p_rp + ptr_t'(ret);
        pc_n       = accept ? pc + ADDR_W'(4) : pc;
        discard_n  = discard - cnt_t'(drop);
        count_n    = count + cnt_t'(push) - cnt_t'(pop);
        q_wp_n     = q_wp + ptr_t'(push);
        q_rp_n     = q_rp + ptr_t'(pop);
        // Redirect: everything still owed by the SRAM is now stale.
        if (fs.br_taken) begin
            pc_n      = fs.br_target;
            discard_n = inflight_n;
            count_n   = '0;
            q_rp_n    = q_wp;
            q_wp_n    = q_wp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            q_wp     <= '0;
            q_rp     <= '0;
            p_wp     <= '0;
            p_rp     <= '0;
        end else begin
            pc       <= pc_n;
            inflight <= inflight_n;
            discard  <= discard_n;
            count    <= count_n;
            q_wp     <= q_wp_n;
            q_rp     <= q_rp_n;
            p_wp     <= p_wp_n;
            p_rp     <= p_rp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p_pc[p_wp] <= pc;
        end
        if (push) begin
            q_pc[q_wp]   <= p_pc[p_rp];
            q_inst[q_wp] <= fs.inst_rdata;
        end
    end
endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: queue-level reference model, in-order SRAM model,
// directed scenarios and a randomised soak with redirects.
module tb_if_stage_fq;
    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_stage_fq_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

    if_stage_fq #(
        .ADDR_W(32), .DATA_W(32), .FQ_DEPTH(4), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fs(bus.master)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'h5a5a_5a5a;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM model: in-order, fixed latency per request, optional data stall
    typedef struct {
        logic [31:0] a;
        int          due;
    } sreq_t;
    sreq_t sq[$];
    int    cyc = 0;
    int    lat = 1;
    bit    data_en = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            sq.delete();
        end else begin
            if (bus.inst_data_ok && sq.size() != 0) void'(sq.pop_front());
            if (bus.inst_req && bus.inst_addr_ok)
                sq.push_back('{bus.inst_addr, cyc + lat});
        end
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        if (!reset && sq.size() != 0 && sq[0].due <= cyc && data_en) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = inst_of(sq[0].a);
        end else begin
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = 32'h0;
        end
    end

    // Reference model: fetch pc, outstanding list with stale marks, queue
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } mi_t;
    mi_t         mi[$];
    logic [31:0] mq[$];
    logic [31:0] mpc = RST_PC;
    bit          mv;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req", 32'(bus.inst_req), 32'd0);
            mi.delete();
            mq.delete();
            mpc = RST_PC;
        end else begin
            mv = (mq.size() != 0) && !bus.br_taken;
            chk("req", 32'(bus.inst_req), 32'(mi.size() + mq.size() < 4));
            if (bus.inst_req) chk("addr", bus.inst_addr, mpc);
            chk("cnt", 32'(bus.fq_count), 32'(mq.size()));
            chk("valid", 32'(bus.fs_to_ds_valid), 32'(mv));
            if (mv) begin
                chk("pc", bus.fs_pc, mq[0]);
                chk("inst", bus.fs_inst, inst_of(mq[0]));
            end
            if (mv && bus.ds_allow_in) void'(mq.pop_front());
            if (bus.inst_data_ok && mi.size() != 0) begin
                mi_t e;
                e = mi.pop_front();
                if (!e.stale) mq.push_back(e.pc);
            end
            if (bus.inst_req && bus.inst_addr_ok) begin
                mi.push_back('{mpc, 1'b0});
                mpc = mpc + 32'd4;
            end
            if (bus.br_taken) begin
                foreach (mi[i]) mi[i].stale = 1'b1;
                mq.delete();
                mpc = bus.br_target;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string nm, int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.fs_to_ds_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic pulse_br(logic [31:0] tgt);
        bus.br_taken  = 1'b1;
        bus.br_target = tgt;
        step();
        bus.br_taken  = 1'b0;
    endtask

    initial begin
        logic [31:0] h;
        bit          ok;
        bus.br_taken     = 1'b0;
        bus.br_target    = 32'h0;
        bus.inst_addr_ok = 1'b1;
        bus.ds_allow_in  = 1'b1;

        // 1: reset state, then back-to-back sequential stream
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t1_rst_cnt", 32'(bus.fq_count), 32'd0);
        chk("t1_rst_valid", 32'(bus.fs_to_ds_valid), 32'd0);
        chk("t1_rst_pc", bus.fs_pc, 32'd0);
        chk("t1_rst_inst", bus.fs_inst, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_first_addr", bus.inst_addr, 32'h1c00_0000);
        wait_valid("t1_wait", 10);
        chk("t1_pc0", bus.fs_pc, 32'h1c00_0000);
        chk("t1_inst0", bus.fs_inst, 32'h465a_5a5a);
        @(negedge clk);
        chk("t1_pc1", bus.fs_pc, 32'h1c00_0004);
        @(negedge clk);
        chk("t1_pc2", bus.fs_pc, 32'h1c00_0008);
        chk("t1_v2", 32'(bus.fs_to_ds_valid), 32'd1);

        // 2: ID stall fills the queue, then four ordered pops
        step();
        bus.ds_allow_in = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t2_full", 32'(bus.fq_count), 32'd4);
        chk("t2_req_off", 32'(bus.inst_req), 32'd0);
        h = bus.fs_pc;
        step();
        bus.ds_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_pop", bus.fs_pc, h + 32'(4 * i));
        end
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            if (bus.inst_req) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t2_resume", 32'(ok), 32'd1);

        // 3: three in flight at latency 3, redirect drops them
        step();
        lat = 3;
        repeat (12) step();
        pulse_br(32'h1c00_0100);
        wait_valid("t3_wait", 30);
        chk("t3_target", bus.fs_pc, 32'h1c00_0100);

        // 4: redirect in the same cycle as an accept and a would-be pop
        step();
        lat = 1;
        repeat (6) step();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0200;
        @(negedge clk);
        chk("t4_req", 32'(bus.inst_req), 32'd1);
        chk("t4_nopop", 32'(bus.fs_to_ds_valid), 32'd0);
        step();
        bus.br_taken = 1'b0;
        @(negedge clk);
        chk("t4_cnt", 32'(bus.fq_count), 32'd0);
        chk("t4_valid", 32'(bus.fs_to_ds_valid), 32'd0);
        chk("t4_addr", bus.inst_addr, 32'h1c00_0200);
        wait_valid("t4_wait", 10);
        chk("t4_pc", bus.fs_pc, 32'h1c00_0200);

        // 5: reset with requests in flight and entries queued
        step();
        lat = 2;
        bus.ds_allow_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.fq_count == 3'd2) ok = 1'b1;
        end
        chk("t5_fill", 32'(ok), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_cnt", 32'(bus.fq_count), 32'd0);
        chk("t5_valid", 32'(bus.fs_to_ds_valid), 32'd0);
        chk("t5_addr", bus.inst_addr, 32'h1c00_0000);
        step();
        bus.ds_allow_in = 1'b1;
        wait_valid("t5_wait", 10);
        chk("t5_pc", bus.fs_pc, 32'h1c00_0000);

        // 6: pc wrap at the top of the address space
        step();
        lat = 1;
        repeat (4) step();
        pulse_br(32'hffff_fffc);
        @(negedge clk);
        chk("t6_addr0", bus.inst_addr, 32'hffff_fffc);
        step();
        @(negedge clk);
        chk("t6_addr1", bus.inst_addr, 32'h0000_0000);
        wait_valid("t6_wait", 10);
        chk("t6_pc0", bus.fs_pc, 32'hffff_fffc);
        @(negedge clk);
        chk("t6_pc1", bus.fs_pc, 32'h0000_0000);

        // Soak: random handshakes, latencies and redirects
        step();
        for (int i = 0; i < 600; i++) begin
            bus.inst_addr_ok = 1'($urandom_range(0, 3) != 0);
            bus.ds_allow_in  = 1'($urandom_range(0, 2) != 0);
            data_en          = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 24) == 0) begin
                bus.br_taken  = 1'b1;
                bus.br_target = $urandom & 32'hffff_fffc;
            end else begin
                bus.br_taken = 1'b0;
            end
            step();
        end
        bus.br_taken     = 1'b0;
        bus.inst_addr_ok = 1'b1;
        bus.ds_allow_in  = 1'b1;
        data_en          = 1'b1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
